// File: rtl/solar_pkg.sv
// Shared types and constants for the solar panel sample scheduler.
// Holds the FSM state encoding, converter timeout and fault-count limit.
package solar_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PERIOD,
        S_SETTLE,
        S_CONVERT,
        S_EVAL
    } state_e;

    localparam int TIMEOUT_CYC = 255;
    localparam int FAULT_LIMIT = 3;

endpackage

// File: rtl/solar_fault_track.sv
// Per-channel low-output counters and sticky fault flags.
// A same-cycle fault set beats a software clear.
module solar_fault_track
    import solar_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              eval_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] threshold_i,
    input  logic [NUM_CH-1:0] clr_i,
    output logic [NUM_CH-1:0] fault_o,
    output logic              irq_o
);

    localparam logic [1:0] LIMIT = 2'(FAULT_LIMIT);

    logic [1:0]        cnt_q [NUM_CH];
    logic [1:0]        cnt_d [NUM_CH];
    logic [NUM_CH-1:0] fault_d;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c]   = clr_i[c] ? 2'd0 : cnt_q[c];
            fault_d[c] = fault_o[c] & ~clr_i[c];
            if (eval_i && (ch_i == CH_W'(c))) begin
                if (data_i < threshold_i) begin
                    cnt_d[c] = (cnt_q[c] == LIMIT) ? LIMIT : cnt_q[c] + 2'd1;
                end else begin
                    cnt_d[c] = 2'd0;
                end
                if (cnt_d[c] == LIMIT) begin
                    fault_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= 2'd0;
            end
            fault_o <= '0;
            irq_o   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            fault_o <= fault_d;
            irq_o   <= |fault_o;
        end
    end

endmodule

// File: rtl/solar_sample_sched.sv
// Sweeps panel sensor channels: settle mux, handshake converter, evaluate.
// Define SOLAR_SCHED_AVG_EN to average four conversions per channel.
module solar_sample_sched
    import solar_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              enable_i,
    input  logic [15:0]       period_i,
    input  logic [DATA_W-1:0] threshold_i,
    output logic [CH_W-1:0]   ch_sel_o,
    output logic              conv_req_o,
    input  logic              conv_ack_i,
    input  logic [DATA_W-1:0] conv_data_i,
    output logic              res_valid_o,
    output logic [CH_W-1:0]   res_ch_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic [NUM_CH-1:0] fault_o,
    input  logic [NUM_CH-1:0] fault_clr_i,
    output logic              timeout_o,
    output logic              irq_o
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]  TO_LAST     = 8'(TIMEOUT_CYC - 1);

    state_e          state_q;
    logic [15:0]     cnt_q;
    logic [7:0]      wait_q;
    logic            last_ch;
    logic [CH_W-1:0] adv_ch;
    state_e          adv_state;

`ifdef SOLAR_SCHED_AVG_EN
    logic [DATA_W+1:0] sum_q;
    logic [DATA_W+1:0] sum_d;
    logic [1:0]        avg_q;

    assign sum_d = sum_q + (DATA_W+2)'(conv_data_i);
`endif

    // Where the sweep goes once a channel is finished (EVAL or timeout).
    always_comb begin
        last_ch = (ch_sel_o == CH_W'(NUM_CH - 1));
        adv_ch  = last_ch ? '0 : ch_sel_o + CH_W'(1);
        if (!enable_i) begin
            adv_state = S_IDLE;
        end else if (!last_ch || (period_i == 16'd0)) begin
            adv_state = S_SETTLE;
        end else begin
            adv_state = S_WAIT_PERIOD;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            ch_sel_o    <= '0;
            conv_req_o  <= 1'b0;
            res_valid_o <= 1'b0;
            res_ch_o    <= '0;
            res_data_o  <= '0;
            timeout_o   <= 1'b0;
            cnt_q       <= '0;
            wait_q      <= '0;
`ifdef SOLAR_SCHED_AVG_EN
            sum_q       <= '0;
            avg_q       <= '0;
`endif
        end else begin
            res_valid_o <= 1'b0;
            timeout_o   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q  <= S_SETTLE;
                        ch_sel_o <= '0;
                        cnt_q    <= '0;
                    end
                end
                S_WAIT_PERIOD: begin
                    if (!enable_i) begin
                        state_q <= S_IDLE;
                    end else if ({1'b0, cnt_q} + 17'd1 >= {1'b0, period_i}) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q    <= S_CONVERT;
                        conv_req_o <= 1'b1;
                        wait_q     <= '0;
`ifdef SOLAR_SCHED_AVG_EN
                        sum_q      <= '0;
                        avg_q      <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_CONVERT: begin
                    if (!conv_req_o) begin
                        conv_req_o <= 1'b1;
                        wait_q     <= '0;
                    end else if (conv_ack_i) begin
                        conv_req_o <= 1'b0;
`ifdef SOLAR_SCHED_AVG_EN
                        sum_q <= sum_d;
                        avg_q <= avg_q + 2'd1;
                        if (avg_q == 2'd3) begin
                            state_q     <= S_EVAL;
                            res_valid_o <= 1'b1;
                            res_ch_o    <= ch_sel_o;
                            res_data_o  <= sum_d[DATA_W+1:2];
                        end
`else
                        state_q     <= S_EVAL;
                        res_valid_o <= 1'b1;
                        res_ch_o    <= ch_sel_o;
                        res_data_o  <= conv_data_i;
`endif
                    end else if (wait_q == TO_LAST) begin
                        // Converter never answered: abandon this channel.
                        conv_req_o <= 1'b0;
                        timeout_o  <= 1'b1;
                        state_q    <= adv_state;
                        ch_sel_o   <= adv_ch;
                        cnt_q      <= '0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_EVAL: begin
                    state_q  <= adv_state;
                    ch_sel_o <= adv_ch;
                    cnt_q    <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    solar_fault_track #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_fault (
        .clk_i       (wb_clk_i),
        .rst_ni      (wb_rst_ni),
        .eval_i      (res_valid_o),
        .ch_i        (res_ch_o),
        .data_i      (res_data_o),
        .threshold_i (threshold_i),
        .clr_i       (fault_clr_i),
        .fault_o     (fault_o),
        .irq_o       (irq_o)
    );

endmodule
